// File: rtl/servo_360_giro.sv
// servo_360_giro: quarter-turn rotation controller for a continuous-rotation servo.
// A command rotates the servo quartos*CICLOS_QUARTO PWM periods in the chosen direction,
// then brakes for PERIODOS_FREIO stop-width periods and pulses pronto for one cycle.
//
// Ports:
//   clock     - system clock
//   reset     - asynchronous, active-high; clears all state and outputs
//   iniciar   - start command, sampled only when idle
//   sentido   - direction (0 = clockwise, 1 = counter-clockwise), captured with iniciar
//   quartos   - quarter turns 0..3, captured with iniciar
//   parar     - abort rotation (acts in PREPARA and GIRA only)
//   pwm       - registered servo drive
//   ocupado   - busy flag (registered)
//   pronto    - one-cycle completion pulse (registered)
//   db_estado - current state code
module servo_360_giro #(
  parameter int unsigned PERIODO         = 1_000_000,
  parameter int unsigned LARGURA_HORARIO = 50_000,
  parameter int unsigned LARGURA_ANTI    = 100_000,
  parameter int unsigned LARGURA_PARADO  = 75_000,
  parameter int unsigned CICLOS_QUARTO   = 25,
  parameter int unsigned PERIODOS_FREIO  = 5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       sentido,
  input  logic [1:0] quartos,
  input  logic       parar,
  output logic       pwm,
  output logic       ocupado,
  output logic       pronto,
  output logic [2:0] db_estado
);

  localparam int unsigned CntW   = (PERIODO > 1) ? $clog2(PERIODO) : 1;
  // Period counter must also reach the brake count, which may exceed 3 quarters.
  localparam int unsigned MaxPer = (3 * CICLOS_QUARTO > PERIODOS_FREIO) ?
                                   3 * CICLOS_QUARTO : PERIODOS_FREIO;
  localparam int unsigned PerW   = $clog2(MaxPer + 1);

  localparam logic [CntW-1:0] CntUlt   = CntW'(PERIODO - 1);
  localparam logic [PerW-1:0] PerFreio = PerW'(PERIODOS_FREIO);

  typedef enum logic [2:0] {
    StInicial = 3'b000,
    StPrepara = 3'b001,
    StGira    = 3'b010,
    StFreia   = 3'b011,
    StFim     = 3'b100
  } estado_e;

  estado_e         estado;
  logic [CntW-1:0] cnt;
  logic [PerW-1:0] per;
  logic [PerW-1:0] alvo;
  logic            sentido_r;
  logic [1:0]      quartos_r;

  logic [31:0]     largura;
  logic            volta;
  logic [PerW-1:0] per_inc;

  always_comb begin
    largura = 32'(LARGURA_PARADO);
    if (estado == StGira) begin
      largura = sentido_r ? 32'(LARGURA_ANTI) : 32'(LARGURA_HORARIO);
    end
  end

  assign volta   = (cnt == CntUlt);
  assign per_inc = per + PerW'(1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado    <= StInicial;
      cnt       <= '0;
      per       <= '0;
      alvo      <= '0;
      sentido_r <= 1'b0;
      quartos_r <= 2'd0;
      pwm       <= 1'b0;
      ocupado   <= 1'b0;
      pronto    <= 1'b0;
    end else begin
      // Outputs follow the state one clock later, like pwm follows cnt.
      pwm     <= ((estado == StGira) || (estado == StFreia)) && (32'(cnt) < largura);
      ocupado <= estado inside {StPrepara, StGira, StFreia};
      pronto  <= (estado == StFim);

      case (estado)
        StInicial: begin
          if (iniciar) begin
            sentido_r <= sentido;
            quartos_r <= quartos;
            estado    <= StPrepara;
          end
        end

        StPrepara: begin
          cnt  <= '0;
          per  <= '0;
          alvo <= PerW'(32'(quartos_r) * CICLOS_QUARTO);
          if (parar) begin
            estado <= StFreia;
          end else if (quartos_r == 2'd0) begin
            estado <= StFim;
          end else begin
            estado <= StGira;
          end
        end

        StGira: begin
          if (parar) begin
            // Abort truncates the pulse in progress and starts braking from phase 0.
            estado <= StFreia;
            cnt    <= '0;
            per    <= '0;
          end else if (volta) begin
            cnt <= '0;
            if (per_inc == alvo) begin
              estado <= StFreia;
              per    <= '0;
            end else begin
              per <= per_inc;
            end
          end else begin
            cnt <= cnt + CntW'(1);
          end
        end

        StFreia: begin
          if (volta) begin
            cnt <= '0;
            if (per_inc == PerFreio) begin
              estado <= StFim;
              per    <= '0;
            end else begin
              per <= per_inc;
            end
          end else begin
            cnt <= cnt + CntW'(1);
          end
        end

        StFim: begin
          estado <= StInicial;
        end

        default: begin
          estado <= StInicial;
        end
      endcase
    end
  end

  assign db_estado = estado;

endmodule

// File: tb/tb_servo_360_giro.sv
// Self-checking bench for servo_360_giro. The reference model describes each command as a
// timeline: 1 cycle PREPARA, G cycles GIRA, F cycles FREIA, 1 cycle FIM, with outputs
// lagging the state by one clock.
module tb_servo_360_giro;

  localparam int P  = 100;
  localparam int WH = 5;
  localparam int WA = 10;
  localparam int WP = 7;
  localparam int CQ = 3;
  localparam int PF = 2;

  logic       clock = 1'b0;
  logic       reset;
  logic       iniciar;
  logic       sentido;
  logic [1:0] quartos;
  logic       parar;
  logic       pwm;
  logic       ocupado;
  logic       pronto;
  logic [2:0] db_estado;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  servo_360_giro #(
    .PERIODO        (P),
    .LARGURA_HORARIO(WH),
    .LARGURA_ANTI   (WA),
    .LARGURA_PARADO (WP),
    .CICLOS_QUARTO  (CQ),
    .PERIODOS_FREIO (PF)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .iniciar  (iniciar),
    .sentido  (sentido),
    .quartos  (quartos),
    .parar    (parar),
    .pwm      (pwm),
    .ocupado  (ocupado),
    .pronto   (pronto),
    .db_estado(db_estado)
  );

  // State code held after the k-th edge counted from the accepting edge (k = 0).
  function automatic int st_at(int k, int g, int f);
    if (k < 0) return 0;
    if (k == 0) return 1;
    if (k <= g) return 2;
    if (k <= g + f) return 3;
    if (k == g + f + 1) return 4;
    return 0;
  endfunction

  // Expected {pwm, ocupado, pronto, db_estado} just after edge k.
  function automatic logic [5:0] expect_at(int k, int g, int f, bit s);
    int   j;
    int   sp;
    logic ep;
    logic eo;
    logic er;
    j  = k - 1;
    sp = st_at(j, g, f);
    ep = 1'b0;
    if (sp == 2) ep = (((j - 1) % P) < (s ? WA : WH));
    if (sp == 3) ep = (((j - 1 - g) % P) < WP);
    eo = (sp == 1) || (sp == 2) || (sp == 3);
    er = (sp == 4);
    return {ep, eo, er, 3'(st_at(k, g, f))};
  endfunction

  // Issues one command and follows it against the model until the cycle pronto is high
  // (or stop_k). pe: edge where parar is high (-1 none); ie: extra iniciar edge (-1 none).
  task automatic run_cmd(input bit s, input logic [1:0] q, input int pe, input int ie,
                         input bit noise, input int stop_k, output int mism,
                         output int pronto_k, output int pwm_hi, output int ocup_hi);
    int         g;
    int         f;
    int         last;
    int         sn;
    logic [5:0] exp_v;
    logic [5:0] obs;
    g = int'(q) * CQ * P;
    f = (q == 2'd0) ? 0 : PF * P;
    if (pe == 1) begin
      g = 0;
      f = PF * P;
    end else if (pe > 1 && pe - 1 < g) begin
      g = pe - 1;
    end
    last = g + f + 2;
    if (stop_k >= 0 && stop_k < last) last = stop_k;
    mism = 0; pronto_k = -1; pwm_hi = 0; ocup_hi = 0;
    @(negedge clock);
    iniciar = 1'b1; sentido = s; quartos = q; parar = (pe == 1);
    for (int k = 0; k <= last; k++) begin
      @(posedge clock); #1;
      obs   = {pwm, ocupado, pronto, db_estado};
      exp_v = expect_at(k, g, f, s);
      if (obs !== exp_v) begin
        if (mism == 0)
          $display("  first divergence %0d cycles after start: got %b want %b", k, obs, exp_v);
        mism++;
      end
      if (pwm === 1'b1) pwm_hi++;
      if (ocupado === 1'b1) ocup_hi++;
      if (pronto === 1'b1 && pronto_k < 0) pronto_k = k;
      if (k < last) begin
        @(negedge clock);
        iniciar = (k + 1 == ie);
        parar   = (k + 1 == pe);
        if (noise) begin
          sentido = 1'($urandom_range(0, 1));
          quartos = 2'($urandom_range(0, 3));
          sn = st_at(k, g, f);
          if (sn != 1 && sn != 2) parar = parar | 1'($urandom_range(0, 1));
          if (sn != 0) iniciar = iniciar | 1'($urandom_range(0, 1));
        end
      end
    end
    iniciar = 1'b0;
    parar   = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; iniciar = 1'b0; sentido = 1'b0; quartos = 2'd0; parar = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    if ({pwm, ocupado, pronto, db_estado} !== 6'b0) begin
      errors++;
      $display("FAIL reset_values: got %b required 000000", {pwm, ocupado, pronto, db_estado});
    end
    checks++;
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(posedge clock); #1;
      if ({pwm, ocupado, db_estado} !== 5'b0) begin
        errors++;
        $display("FAIL idle_cycle_%0d: got %b required 00000", i, {pwm, ocupado, db_estado});
      end
      checks++;
    end
  endtask

  task automatic test_cw_one_quarter();
    int m, pk, ph, oh;
    run_cmd(1'b0, 2'd1, -1, -1, 1'b0, -1, m, pk, ph, oh);
    if (m !== 0) begin errors++; $display("FAIL cw1_waveform: got %0d bad cycles required 0", m); end
    checks++;
    if (pk !== 502) begin errors++; $display("FAIL cw1_pronto: got %0d required 502", pk); end
    checks++;
    if (ph !== 29) begin errors++; $display("FAIL cw1_pwm_high: got %0d required 29", ph); end
    checks++;
    if (oh !== 501) begin errors++; $display("FAIL cw1_ocupado: got %0d required 501", oh); end
    checks++;
  endtask

  task automatic test_ccw_three_quarters();
    int m, pk, ph, oh;
    run_cmd(1'b1, 2'd3, -1, -1, 1'b0, -1, m, pk, ph, oh);
    if (m !== 0) begin errors++; $display("FAIL ccw3_waveform: got %0d bad cycles required 0", m); end
    checks++;
    if (pk !== 1102) begin errors++; $display("FAIL ccw3_pronto: got %0d required 1102", pk); end
    checks++;
    if (ph !== 104) begin errors++; $display("FAIL ccw3_pwm_high: got %0d required 104", ph); end
    checks++;
  endtask

  task automatic test_zero_quarters();
    int m, pk, ph, oh;
    run_cmd(1'b0, 2'd0, -1, -1, 1'b0, -1, m, pk, ph, oh);
    if (m !== 0) begin errors++; $display("FAIL q0_waveform: got %0d bad cycles required 0", m); end
    checks++;
    if (pk !== 2) begin errors++; $display("FAIL q0_pronto: got %0d required 2", pk); end
    checks++;
    if (ph !== 0) begin errors++; $display("FAIL q0_pwm_high: got %0d required 0", ph); end
    checks++;
  endtask

  task automatic test_abort();
    int m, pk, ph, oh;
    // parar at edge 151 (150 cycles into GIRA); extra iniciar at edge 200 lands in FREIA.
    run_cmd(1'b0, 2'd2, 151, 200, 1'b0, -1, m, pk, ph, oh);
    if (m !== 0) begin errors++; $display("FAIL abort_waveform: got %0d bad cycles required 0", m); end
    checks++;
    if (pk !== 352) begin errors++; $display("FAIL abort_pronto: got %0d required 352", pk); end
    checks++;
    if (ph !== 24) begin errors++; $display("FAIL abort_pwm_high: got %0d required 24", ph); end
    checks++;
    @(posedge clock); #1;
    if (db_estado !== 3'b000) begin
      errors++; $display("FAIL abort_no_requeue: got %b required 000", db_estado);
    end
    checks++;
  endtask

  task automatic test_start_with_abort();
    int m, pk, ph, oh;
    run_cmd(1'b1, 2'd3, 1, -1, 1'b0, -1, m, pk, ph, oh);
    if (m !== 0) begin errors++; $display("FAIL startabort_waveform: got %0d bad cycles required 0", m); end
    checks++;
    if (pk !== 202) begin errors++; $display("FAIL startabort_pronto: got %0d required 202", pk); end
    checks++;
    if (ph !== 14) begin errors++; $display("FAIL startabort_pwm_high: got %0d required 14", ph); end
    checks++;
  endtask

  task automatic test_reset_mid_gira();
    int m, pk, ph, oh;
    run_cmd(1'b0, 2'd1, -1, -1, 1'b0, 3, m, pk, ph, oh);
    if (m !== 0 || pwm !== 1'b1) begin
      errors++; $display("FAIL midreset_pre: got %0d bad cycles pwm=%b required 0 pwm=1", m, pwm);
    end
    checks++;
    #1 reset = 1'b1;
    #1;
    if ({pwm, ocupado, pronto, db_estado} !== 6'b0) begin
      errors++;
      $display("FAIL midreset_async: got %b required 000000", {pwm, ocupado, pronto, db_estado});
    end
    checks++;
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;
    if ({pwm, ocupado, db_estado} !== 5'b0) begin
      errors++; $display("FAIL midreset_after: got %b required 00000", {pwm, ocupado, db_estado});
    end
    checks++;
    run_cmd(1'b1, 2'd2, -1, -1, 1'b0, -1, m, pk, ph, oh);
    if (m !== 0) begin errors++; $display("FAIL midreset_rerun: got %0d bad cycles required 0", m); end
    checks++;
    if (pk !== 802) begin errors++; $display("FAIL midreset_pronto: got %0d required 802", pk); end
    checks++;
  endtask

  task automatic test_random();
    int m, pk, ph, oh;
    int q, s, pe, lat, gap, g;
    for (int n = 0; n < 6; n++) begin
      s  = int'($urandom_range(0, 1));
      q  = int'($urandom_range(0, 3));
      pe = -1;
      if ($urandom_range(0, 2) == 0) pe = int'($urandom_range(1, q * CQ * P + 1));
      if (pe == 1) lat = 2 + PF * P;
      else if (q == 0) lat = 2;
      else begin
        g = q * CQ * P;
        if (pe > 1 && pe - 1 < g) g = pe - 1;
        lat = 2 + g + PF * P;
      end
      run_cmd(1'(s), 2'(q), pe, -1, 1'b1, -1, m, pk, ph, oh);
      if (m !== 0) begin
        errors++; $display("FAIL rand%0d_waveform: got %0d bad cycles required 0", n, m);
      end
      checks++;
      if (pk !== lat) begin
        errors++; $display("FAIL rand%0d_pronto: got %0d required %0d", n, pk, lat);
      end
      checks++;
      // Gap 0 starts the next command on the earliest accepting edge.
      gap = int'($urandom_range(0, 3));
      for (int i = 0; i < gap; i++) begin
        @(posedge clock); #1;
        if ({pwm, ocupado, db_estado} !== 5'b0) begin
          errors++; $display("FAIL rand%0d_gap: got %b required 00000", n, {pwm, ocupado, db_estado});
        end
        checks++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_cw_one_quarter();
    test_ccw_three_quarters();
    test_zero_quarters();
    test_abort();
    test_start_with_abort();
    test_reset_mid_gira();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got time limit reached required bench completion");
    $fatal(1, "bench did not complete");
  end

endmodule
